// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, per-word framing/parity error flags,
// and a show-ahead receive FIFO with a valid/ready handshake and a sticky overrun flag.
module uart_rx_fifo #(
   parameter int divisor    = 10,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          frame,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_parity_err,
   output logic                          rx_frame_err,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   input  logic                          overrun_clr,
   output logic                          rx_busy
);

   // state  | meaning
   // IDLE   | line idle, waiting for a falling edge
   // START  | half a bit into the start bit, confirming it is still low
   // DATA   | deciding data bits, LSB first
   // PAR    | deciding the parity bit
   // STOP   | deciding stop bits; the last one pushes the word
   // BREAK  | framing error seen, waiting for the line to return high
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_BREAK
   } state_t;

   localparam int CW   = $clog2(divisor + 1);
   localparam int IW   = $clog2(DATA_BITS + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int WW   = DATA_BITS + 2;

   localparam logic [CW-1:0]   CNT_S1   = CW'(divisor - 3);
   localparam logic [CW-1:0]   CNT_S2   = CW'(divisor - 2);
   localparam logic [CW-1:0]   CNT_LAST = CW'(divisor - 1);
   localparam logic [CW-1:0]   CNT_HALF = CW'(divisor / 2 - 1);
   localparam logic [IW-1:0]   IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

   logic                 sync1_q, sync2_q;
   logic                 s;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 bit_end;
   logic                 maj;
   logic                 push;
   logic [WW-1:0]        push_word;

   logic [WW-1:0]        mem_q [FIFO_DEPTH];
   logic [WW-1:0]        mem_d [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic                 overrun_q, overrun_d;
   logic                 full;
   logic                 do_pop;
   logic                 do_push;
   logic                 drop;
   logic [WW-1:0]        head;

   assign s       = sync2_q;
   assign bit_end = (cnt_q == CNT_LAST);
   assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & s) | (samp_q[1] & s);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      stop_idx_d = stop_idx_q;
      push       = 1'b0;
      push_word  = {ferr_q, perr_q, shift_q};

      if (cnt_q == CNT_S1) samp_d[0] = s;
      if (cnt_q == CNT_S2) samp_d[1] = s;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!s) begin
                  idx_d      = '0;
                  perr_d     = 1'b0;
                  ferr_d     = 1'b0;
                  stop_idx_d = 1'b0;
                  state_d    = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               // Shifting in from the top leaves the first bit at [0] after DATA_BITS shifts.
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_PAR: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               perr_d  = (PARITY == 2) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               ferr_d = ferr_q | ~maj;
               if (stop_idx_q == STOP_LAST) begin
                  push      = 1'b1;
                  push_word = {ferr_d, perr_q, shift_q};
                  cnt_d     = '0;
                  state_d   = ferr_d ? S_BREAK : S_IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign full    = (count_q == CNT_FULL);
   assign rx_valid = (count_q != '0);
   assign do_pop  = rx_valid & rx_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_word;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CNTW'(1);
      else if (!do_push && do_pop) count_d = count_q - CNTW'(1);
   end

   always_comb begin
      overrun_d = overrun_q;
      if (overrun_clr) overrun_d = 1'b0;
      if (drop)        overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         samp_q     <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         stop_idx_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sync1_q    <= frame;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         stop_idx_q <= stop_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         mem_q      <= mem_d;
      end
   end

   assign head          = mem_q[rd_ptr_q];
   assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_parity_err = rx_valid & head[DATA_BITS];
   assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
   assign fifo_count    = count_q;
   assign overrun       = overrun_q;
   assign rx_busy       = (state_q != S_IDLE) && (state_q != S_BREAK);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 receiver (a) and an 8E1 receiver (b), divisor 10.
module tb_uart_rx_fifo;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       frame_a = 1'b1, rx_ready_a = 1'b0, overrun_clr_a = 1'b0;
   logic [7:0] rx_data_a;
   logic       rx_parity_err_a, rx_frame_err_a, rx_valid_a, overrun_a, rx_busy_a;
   logic [2:0] fifo_count_a;

   logic       frame_b = 1'b1, rx_ready_b = 1'b0, overrun_clr_b = 1'b0;
   logic [7:0] rx_data_b;
   logic       rx_parity_err_b, rx_frame_err_b, rx_valid_b, overrun_b, rx_busy_b;
   logic [2:0] fifo_count_b;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.divisor(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst(rst), .frame(frame_a),
      .rx_data(rx_data_a), .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a),
      .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .fifo_count(fifo_count_a),
      .overrun(overrun_a), .overrun_clr(overrun_clr_a), .rx_busy(rx_busy_a)
   );

   uart_rx_fifo #(.divisor(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .rst(rst), .frame(frame_b),
      .rx_data(rx_data_b), .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b),
      .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .fifo_count(fifo_count_b),
      .overrun(overrun_b), .overrun_clr(overrun_clr_b), .rx_busy(rx_busy_b)
   );

   // Drives one frame starting at the current negedge; one slot per DIV negedges.
   // glitch_n inverts the line for the single negedge-to-negedge interval with that index.
   task automatic send_frame(input int which, input logic [7:0] data, input logic has_par,
                             input logic par_bit, input logic stop_val, input int glitch_n);
      logic [11:0] slots;
      int          nslots;
      logic        b;
      slots    = '1;
      slots[0] = 1'b0;
      for (int i = 0; i < 8; i++) slots[1+i] = data[i];
      nslots = 9;
      if (has_par) begin
         slots[9] = par_bit;
         nslots   = 10;
      end
      slots[nslots] = stop_val;
      nslots++;
      for (int n = 0; n < nslots * DIV; n++) begin
         b = slots[n / DIV] ^ (n == glitch_n);
         if (which == 0) frame_a = b;
         else            frame_b = b;
         @(negedge clk);
      end
   endtask

   task automatic pop_a();
      rx_ready_a = 1'b1;
      @(negedge clk);
      rx_ready_a = 1'b0;
   endtask

   task automatic pop_b();
      rx_ready_b = 1'b1;
      @(negedge clk);
      rx_ready_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++; if (rx_data_a !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data got %h expected 00", rx_data_a); end
      tests_run++; if (rx_parity_err_a !== 1'b0) begin tests_failed++; $display("FAIL reset_parity_err got %b expected 0", rx_parity_err_a); end
      tests_run++; if (rx_frame_err_a !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err got %b expected 0", rx_frame_err_a); end
      tests_run++; if (rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid got %b expected 0", rx_valid_a); end
      tests_run++; if (fifo_count_a !== 3'd0) begin tests_failed++; $display("FAIL reset_fifo_count got %0d expected 0", fifo_count_a); end
      tests_run++; if (overrun_a !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b expected 0", overrun_a); end
      tests_run++; if (rx_busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_busy got %b expected 0", rx_busy_a); end
      tests_run++; if (rx_valid_b !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid_b got %b expected 0", rx_valid_b); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // Last stop decision lands on the posedge 98 cycles after the start edge; with
   // rx_ready held high each word is visible for exactly one sample.
   task automatic test_back_to_back();
      int nvalid;
      nvalid = 0;
      rx_ready_a = 1'b1;
      fork
         begin
            send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
            send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
         end
         begin
            for (int n = 1; n <= 200; n++) begin
               @(negedge clk);
               if (rx_valid_a) nvalid++;
               if (n == 97 || n == 99 || n == 197 || n == 199) begin
                  tests_run++;
                  if (rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_valid_low n=%0d got %b expected 0", n, rx_valid_a); end
               end
               if (n == 98 || n == 198) begin
                  tests_run++;
                  if (rx_valid_a !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid_high n=%0d got %b expected 1", n, rx_valid_a); end
                  tests_run++;
                  if (rx_data_a !== ((n == 98) ? 8'hA5 : 8'h3C)) begin
                     tests_failed++; $display("FAIL b2b_data n=%0d got %h expected %h", n, rx_data_a, (n == 98) ? 8'hA5 : 8'h3C);
                  end
                  tests_run++;
                  if ({rx_frame_err_a, rx_parity_err_a} !== 2'b00) begin
                     tests_failed++; $display("FAIL b2b_flags n=%0d got %b expected 00", n, {rx_frame_err_a, rx_parity_err_a});
                  end
               end
            end
         end
      join
      rx_ready_a = 1'b0;
      tests_run++; if (nvalid != 2) begin tests_failed++; $display("FAIL b2b_word_count got %0d expected 2", nvalid); end
      tests_run++; if (overrun_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %b expected 0", overrun_a); end
   endtask

   // 0x37 has five ones, so even parity needs parity bit 1.
   task automatic test_parity();
      send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1, -1);
      tests_run++; if (rx_valid_b !== 1'b1) begin tests_failed++; $display("FAIL par_ok_valid got %b expected 1", rx_valid_b); end
      tests_run++; if (rx_data_b !== 8'h37) begin tests_failed++; $display("FAIL par_ok_data got %h expected 37", rx_data_b); end
      tests_run++; if (rx_parity_err_b !== 1'b0) begin tests_failed++; $display("FAIL par_ok_perr got %b expected 0", rx_parity_err_b); end
      tests_run++; if (rx_frame_err_b !== 1'b0) begin tests_failed++; $display("FAIL par_ok_ferr got %b expected 0", rx_frame_err_b); end
      pop_b();
      send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1, -1);
      tests_run++; if (rx_valid_b !== 1'b1) begin tests_failed++; $display("FAIL par_bad_valid got %b expected 1", rx_valid_b); end
      tests_run++; if (rx_data_b !== 8'h37) begin tests_failed++; $display("FAIL par_bad_data got %h expected 37", rx_data_b); end
      tests_run++; if (rx_parity_err_b !== 1'b1) begin tests_failed++; $display("FAIL par_bad_perr got %b expected 1", rx_parity_err_b); end
      tests_run++; if (rx_frame_err_b !== 1'b0) begin tests_failed++; $display("FAIL par_bad_ferr got %b expected 0", rx_frame_err_b); end
      pop_b();
      tests_run++; if (fifo_count_b !== 3'd0) begin tests_failed++; $display("FAIL par_drained got %0d expected 0", fifo_count_b); end
   endtask

   task automatic test_noise();
      frame_a = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (rx_busy_a !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy got %b expected 1", rx_busy_a); end
      frame_a = 1'b1;
      repeat (20) @(negedge clk);
      tests_run++; if (rx_busy_a !== 1'b0) begin tests_failed++; $display("FAIL glitch_idle got %b expected 0", rx_busy_a); end
      tests_run++; if (rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL glitch_no_word got %b expected 0", rx_valid_a); end
      // Index 44 is inside data bit 3 and reaches the middle vote sample only.
      send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 44);
      tests_run++; if (rx_valid_a !== 1'b1) begin tests_failed++; $display("FAIL vote_valid got %b expected 1", rx_valid_a); end
      tests_run++; if (rx_data_a !== 8'h00) begin tests_failed++; $display("FAIL vote_data got %h expected 00", rx_data_a); end
      tests_run++; if ({rx_frame_err_a, rx_parity_err_a} !== 2'b00) begin tests_failed++; $display("FAIL vote_flags got %b expected 00", {rx_frame_err_a, rx_parity_err_a}); end
      pop_a();
   endtask

   task automatic test_framing();
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
      frame_a = 1'b0;
      repeat (30) @(negedge clk);
      tests_run++; if (fifo_count_a !== 3'd1) begin tests_failed++; $display("FAIL brk_count got %0d expected 1", fifo_count_a); end
      tests_run++; if (rx_data_a !== 8'h55) begin tests_failed++; $display("FAIL brk_data got %h expected 55", rx_data_a); end
      tests_run++; if (rx_frame_err_a !== 1'b1) begin tests_failed++; $display("FAIL brk_ferr got %b expected 1", rx_frame_err_a); end
      tests_run++; if (rx_parity_err_a !== 1'b0) begin tests_failed++; $display("FAIL brk_perr got %b expected 0", rx_parity_err_a); end
      tests_run++; if (rx_busy_a !== 1'b0) begin tests_failed++; $display("FAIL brk_busy got %b expected 0", rx_busy_a); end
      frame_a = 1'b1;
      repeat (30) @(negedge clk);
      tests_run++; if (fifo_count_a !== 3'd1) begin tests_failed++; $display("FAIL brk_release_count got %0d expected 1", fifo_count_a); end
      tests_run++; if (rx_busy_a !== 1'b0) begin tests_failed++; $display("FAIL brk_release_busy got %b expected 0", rx_busy_a); end
      pop_a();
   endtask

   task automatic test_overrun();
      logic [7:0] w;
      for (int i = 1; i <= 5; i++) begin
         w = 8'(i);
         send_frame(0, w, 1'b0, 1'b0, 1'b1, -1);
      end
      tests_run++; if (fifo_count_a !== 3'd4) begin tests_failed++; $display("FAIL ovr_count got %0d expected 4", fifo_count_a); end
      tests_run++; if (overrun_a !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b expected 1", overrun_a); end
      for (int i = 1; i <= 4; i++) begin
         tests_run++;
         if (rx_data_a !== 8'(i)) begin tests_failed++; $display("FAIL ovr_drain%0d got %h expected %h", i, rx_data_a, 8'(i)); end
         pop_a();
      end
      tests_run++; if (rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL ovr_empty got %b expected 0", rx_valid_a); end
      tests_run++; if (overrun_a !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky got %b expected 1", overrun_a); end
      overrun_clr_a = 1'b1;
      @(negedge clk);
      overrun_clr_a = 1'b0;
      tests_run++; if (overrun_a !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b expected 0", overrun_a); end
   endtask

   task automatic test_full_boundary();
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
      send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, -1);
      send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1, -1);
      tests_run++; if (fifo_count_a !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d expected 4", fifo_count_a); end
      fork
         send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1, -1);
         begin
            repeat (97) @(negedge clk);
            rx_ready_a = 1'b1;
            @(negedge clk);
            rx_ready_a = 1'b0;
            tests_run++; if (fifo_count_a !== 3'd4) begin tests_failed++; $display("FAIL full_pushpop_count got %0d expected 4", fifo_count_a); end
            tests_run++; if (overrun_a !== 1'b0) begin tests_failed++; $display("FAIL full_pushpop_overrun got %b expected 0", overrun_a); end
            tests_run++; if (rx_data_a !== 8'h22) begin tests_failed++; $display("FAIL full_pushpop_head got %h expected 22", rx_data_a); end
         end
      join
      pop_a();
      tests_run++; if (rx_data_a !== 8'h33) begin tests_failed++; $display("FAIL full_drain33 got %h expected 33", rx_data_a); end
      pop_a();
      tests_run++; if (rx_data_a !== 8'h44) begin tests_failed++; $display("FAIL full_drain44 got %h expected 44", rx_data_a); end
      pop_a();
      tests_run++; if (rx_data_a !== 8'h66) begin tests_failed++; $display("FAIL full_drain66 got %h expected 66", rx_data_a); end
      pop_a();
      tests_run++; if (fifo_count_a !== 3'd0) begin tests_failed++; $display("FAIL full_drained got %0d expected 0", fifo_count_a); end
   endtask

   task automatic test_reset_midframe();
      send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
      tests_run++; if (fifo_count_a !== 3'd1) begin tests_failed++; $display("FAIL mid_pre_count got %0d expected 1", fifo_count_a); end
      fork
         send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, -1);
         begin
            repeat (55) @(negedge clk);
            tests_run++; if (rx_busy_a !== 1'b1) begin tests_failed++; $display("FAIL mid_busy got %b expected 1", rx_busy_a); end
            rst = 1'b1;
            @(negedge clk);
            tests_run++; if (rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got %b expected 0", rx_valid_a); end
            tests_run++; if (fifo_count_a !== 3'd0) begin tests_failed++; $display("FAIL mid_rst_count got %0d expected 0", fifo_count_a); end
            tests_run++; if (rx_data_a !== 8'h00) begin tests_failed++; $display("FAIL mid_rst_data got %h expected 00", rx_data_a); end
            tests_run++; if ({rx_frame_err_a, rx_parity_err_a, overrun_a} !== 3'b000) begin
               tests_failed++; $display("FAIL mid_rst_flags got %b expected 000", {rx_frame_err_a, rx_parity_err_a, overrun_a});
            end
            tests_run++; if (rx_busy_a !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy got %b expected 0", rx_busy_a); end
            rst = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      tests_run++; if (fifo_count_a !== 3'd0) begin tests_failed++; $display("FAIL mid_no_word got %0d expected 0", fifo_count_a); end
      tests_run++; if (rx_busy_a !== 1'b0) begin tests_failed++; $display("FAIL mid_idle got %b expected 0", rx_busy_a); end
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
      tests_run++; if (rx_valid_a !== 1'b1) begin tests_failed++; $display("FAIL mid_resume_valid got %b expected 1", rx_valid_a); end
      tests_run++; if (rx_data_a !== 8'h5A) begin tests_failed++; $display("FAIL mid_resume_data got %h expected 5a", rx_data_a); end
      pop_a();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_parity();
      test_noise();
      test_framing();
      test_overrun();
      test_full_boundary();
      test_reset_midframe();
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver for the serial link.
- Frame format set at elaboration: data bit count, parity mode, stop bit count.
- Line is double-flop synchronised; each bit is decided by a 3-sample majority vote at bit centre.
- Framing and parity errors are flagged per word, and received words are buffered in an output FIFO with a valid/ready handshake and overrun detection.
- Sits between the serial pin and the memory-mapped register block, replacing the single-word `ready`/`data` style receiver.

Parameters:
divisor, 10, clock cycles per bit; legal range 4..2047.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, number of words in the receive FIFO; power of 2, at least 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
frame  in  1  asynchronous serial line; idles high.
rx_data  out  DATA_BITS  head-of-FIFO data word.
rx_parity_err  out  1  parity error flag of the head word.
rx_frame_err  out  1  framing error flag of the head word.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer accept; a pop occurs when rx_valid && rx_ready.
fifo_count  out  clog2(FIFO_DEPTH)+1  number of words held.
overrun  out  1  sticky; set when a word is dropped because the FIFO is full.
overrun_clr  in  1  clears overrun.
rx_busy  out  1  high in any state other than IDLE and BREAK.

Behaviour:
- Synchroniser: two flops on `frame`, both reset to 1. All logic below uses the synchronised line `s`.
- Majority: within a bit period, `cnt` counts 0..divisor-1. `s` is sampled at cnt = divisor-3, divisor-2 and divisor-1. The bit value is the majority of the 3 samples and is decided on the edge where cnt = divisor-1; cnt then returns to 0.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
  - IDLE: when s = 0, cnt <= 0 and go to START.
  - START: count to divisor/2-1 (integer division), then re-check s.
    - s = 0: cnt <= 0, bit index <= 0, go to DATA.
    - s = 1: glitch; return to IDLE with no push.
  - DATA: decided bit goes to shift-register position [index], LSB first. After bit DATA_BITS-1, go to PAR if PARITY != 0, else go to STOP.
  - PAR: decide the parity bit.
    - Even: parity_err = XOR(data, parity bit).
    - Odd: parity_err = inverse of that.
    - Go to STOP.
  - STOP: decide STOP_BITS stop bits. frame_err = 1 if any stop bit decides 0. On the edge deciding the last stop bit:
    - Push {frame_err, parity_err, data}.
    - If frame_err = 0, go to IDLE (half a bit early, for resync).
    - If frame_err = 1, go to BREAK.
  - BREAK: wait for s = 1, then go to IDLE. A held-low line produces exactly one error word.
- Latency: the word is written on the last-stop-decision edge. If the FIFO was empty, rx_valid = 1 in the next cycle.
- FIFO behaviour:
  - Show-ahead: rx_data and the two flags always reflect the head word while rx_valid = 1.
  - Pop only when rx_valid && rx_ready. rx_ready while empty has no effect.
  - Push while full with no pop: the new word is dropped, FIFO contents are unchanged, and overrun <= 1.
  - Push and pop in the same cycle while full: both succeed, count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only; the word appears next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count holds 0..FIFO_DEPTH.
- Overrun: overrun_clr clears the flag. If a set condition and overrun_clr occur in the same cycle, set wins.
- Reset values:
  - Outputs: rx_data 0, rx_parity_err 0, rx_frame_err 0, rx_valid 0, fifo_count 0, overrun 0, rx_busy 0.
  - Internal: FSM = IDLE, pointers 0, counters 0.
- Reset mid-frame: the partial frame is discarded and no push occurs. The receiver resumes in IDLE the cycle after rst deasserts.

Test Plan:
- divisor=10, 8N1: send 0xA5, then 0x3C back-to-back with rx_ready=1 -> two words 0xA5 and 0x3C, both flags 0, overrun 0; rx_valid rises 1 cycle after each last-stop decision.
- PARITY=1 (even): send 0x37 with parity bit 1 (correct) -> parity_err=0. Send 0x37 with parity bit 0 -> rx_data=0x37, parity_err=1.
- Noise:
  - Low pulse of 3 cycles on an idle line -> no word, rx_busy returns to 0.
  - 1-cycle inversion at cnt=divisor-2 inside data bit 3 of 0x00 -> 0x00 received, no errors.
- Framing: send 0x55 with stop bit 0, then hold the line low for 30 cycles -> one word 0x55 with frame_err=1, FSM in BREAK, and no further word until the line returns high.
- Overrun: FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> fifo_count=4, overrun=1, drained order 0x01..0x04 (0x05 dropped). Pulse overrun_clr -> overrun=0.
- Reset and full boundary:
  - Assert rst during data bit 4 -> no word; all outputs at reset values.
  - With the FIFO full, hold rx_ready=1 on the push edge -> count stays 4, overrun stays 0.
